// File: rtl/serial_parity_checker.sv
// Serial frame parity checker: folds data bits through a running XOR and
// compares against the trailing parity bit, keeping a saturating error count.
module serial_parity_checker #(
   parameter int unsigned DATA_BITS = 8,
   parameter bit          ODD       = 1'b0,
   parameter int unsigned CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             bit_i,
   input  logic             bit_valid_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             parity_o,
   output logic             err_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   localparam int unsigned BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [BC_W-1:0] LAST = BC_W'(DATA_BITS - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DATA  = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;

   logic [1:0]      state_q, state_d;
   logic            acc_q, acc_d;
   logic [BC_W-1:0] cnt_q, cnt_d;
   logic            done_q, done_d;
   logic            par_q, par_d;
   logic            err_q, err_d;
   logic [CNT_W-1:0] ecnt_q, ecnt_d;
   logic            exp_par;
   logic            mismatch;

   assign exp_par  = acc_q ^ ODD;
   assign mismatch = bit_i ^ exp_par;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      par_d   = par_q;
      err_d   = err_q;
      ecnt_d  = ecnt_q;
      if (abort_i) begin
         // abort wins over every other input and leaves verdicts untouched
         state_d = S_IDLE;
         acc_d   = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_d = S_DATA;
                  acc_d   = 1'b0;
                  cnt_d   = '0;
               end
            end
            S_DATA: begin
               if (bit_valid_i) begin
                  acc_d = acc_q ^ bit_i;
                  cnt_d = cnt_q + BC_W'(1);
                  if (cnt_q == LAST) begin
                     state_d = S_CHECK;
                  end
               end
            end
            S_CHECK: begin
               if (bit_valid_i) begin
                  state_d = S_IDLE;
                  acc_d   = 1'b0;
                  cnt_d   = '0;
                  done_d  = 1'b1;
                  par_d   = exp_par;
                  err_d   = mismatch;
                  if (mismatch && (ecnt_q != '1)) begin
                     ecnt_d = ecnt_q + CNT_W'(1);
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
               acc_d   = 1'b0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         par_q   <= 1'b0;
         err_q   <= 1'b0;
         ecnt_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         par_q   <= par_d;
         err_q   <= err_d;
         ecnt_q  <= ecnt_d;
      end
   end

   assign busy_o    = (state_q != S_IDLE);
   assign done_o    = done_q;
   assign parity_o  = par_q;
   assign err_o     = err_q;
   assign err_cnt_o = ecnt_q;

endmodule
